// File: rtl/nabp_pkg.sv
// Shared types and constants for the NABP backprojector swap/parameter path.
package nabp_pkg;

   localparam int NUM_UNITS      = 2;
   localparam int SH_ACCU_W      = 16;
   localparam int MP_ACCU_INIT_W = 16;
   localparam int MP_ACCU_BASE_W = 16;

   typedef logic [SH_ACCU_W-1:0]      t_shift_accu_base;
   typedef logic [MP_ACCU_INIT_W-1:0] t_map_accu_init;
   typedef logic [MP_ACCU_BASE_W-1:0] t_map_accu_base;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_SWAP,
      DRAIN,
      NEXT_ITR
   } swap_ctl_state_t;

endpackage

// File: rtl/nabp_angle_param_fetch.sv
// Holds the angle LUT address and captures the LUT data (1-cycle latency)
// into the parameter bus registers shared by both swappable units.
module nabp_angle_param_fetch
   import nabp_pkg::*;
#(
   parameter int ANGLE_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_addr,
   input  logic [ANGLE_W-1:0] addr,
   input  logic               capture,
   input  t_shift_accu_base   lut_sh_accu_base,
   input  t_map_accu_init     lut_mp_accu_init,
   input  t_map_accu_base     lut_mp_accu_base,
   output logic [ANGLE_W-1:0] lut_angle,
   output t_shift_accu_base   sh_accu_base,
   output t_map_accu_init     mp_accu_init,
   output t_map_accu_base     mp_accu_base
);

   logic [ANGLE_W-1:0] lut_angle_q, lut_angle_d;
   t_shift_accu_base   sh_accu_base_q, sh_accu_base_d;
   t_map_accu_init     mp_accu_init_q, mp_accu_init_d;
   t_map_accu_base     mp_accu_base_q, mp_accu_base_d;

   always_comb begin
      lut_angle_d    = load_addr ? addr : lut_angle_q;
      sh_accu_base_d = capture ? lut_sh_accu_base : sh_accu_base_q;
      mp_accu_init_d = capture ? lut_mp_accu_init : mp_accu_init_q;
      mp_accu_base_d = capture ? lut_mp_accu_base : mp_accu_base_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lut_angle_q    <= '0;
         sh_accu_base_q <= '0;
         mp_accu_init_q <= '0;
         mp_accu_base_q <= '0;
      end else begin
         lut_angle_q    <= lut_angle_d;
         sh_accu_base_q <= sh_accu_base_d;
         mp_accu_init_q <= mp_accu_init_d;
         mp_accu_base_q <= mp_accu_base_d;
      end
   end

   assign lut_angle    = lut_angle_q;
   assign sh_accu_base = sh_accu_base_q;
   assign mp_accu_init = mp_accu_init_q;
   assign mp_accu_base = mp_accu_base_q;

endmodule

// File: rtl/nabp_swap_control.sv
// Ping-pong swap sequencer: walks every angle of each iteration, hands out
// the angle parameters on each swap and gives PE ownership to the unit that just filled.
module nabp_swap_control
   import nabp_pkg::*;
#(
   parameter int NO_OF_ANGLES     = 180,
   parameter int NO_OF_ITERATIONS = 4,
   parameter int ANGLE_W          = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ANGLE_W-1:0]   lut_angle,
   input  t_shift_accu_base     lut_sh_accu_base,
   input  t_map_accu_init       lut_mp_accu_init,
   input  t_map_accu_base       lut_mp_accu_base,
   input  logic [NUM_UNITS-1:0] sw_swap,
   input  logic [NUM_UNITS-1:0] sw_next_itr,
   output logic [NUM_UNITS-1:0] sw_swap_ack,
   output logic [NUM_UNITS-1:0] sw_next_itr_ack,
   output logic [NUM_UNITS-1:0] sw_pe_en,
   output logic                 sw_param_valid,
   output t_shift_accu_base     sw_sh_accu_base,
   output t_map_accu_init       sw_mp_accu_init,
   output t_map_accu_base       sw_mp_accu_base,
   output logic                 pe_sel
);

   localparam int S_W   = $clog2(NO_OF_ANGLES + 2);
   localparam int ITR_W = $clog2(NO_OF_ITERATIONS) + 1;
   localparam logic [NUM_UNITS-1:0] ALL_UNITS = '1;

   swap_ctl_state_t      state_q, state_d;
   logic                 phase_q, phase_d;
   logic [S_W-1:0]       s_q, s_d, s_inc;
   logic [ANGLE_W-1:0]   angle_q, angle_d;
   logic [ITR_W-1:0]     itr_q, itr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [NUM_UNITS-1:0] swap_ack_q, swap_ack_d;
   logic [NUM_UNITS-1:0] next_itr_ack_q, next_itr_ack_d;
   logic [NUM_UNITS-1:0] pe_en_q, pe_en_d;
   logic                 pe_sel_q, pe_sel_d;
   logic                 param_valid_q, param_valid_d;
   logic                 load_addr, capture, swap_ok, itr_ok, fill_unit;

   assign s_inc     = s_q + S_W'(1);
   assign fill_unit = s_q[0];
   // Requests still high during their own ack cycle are stale, not new requests.
   assign swap_ok   = (sw_swap == ALL_UNITS) && (swap_ack_q == '0);
   assign itr_ok    = (sw_next_itr == ALL_UNITS) && (next_itr_ack_q == '0);

   always_comb begin
      state_d        = state_q;
      phase_d        = 1'b0;
      s_d            = s_q;
      angle_d        = angle_q;
      itr_d          = itr_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      err_d          = err_q;
      swap_ack_d     = '0;
      next_itr_ack_d = '0;
      pe_en_d        = pe_en_q;
      pe_sel_d       = pe_sel_q;
      param_valid_d  = 1'b0;
      load_addr      = 1'b0;
      capture        = 1'b0;

      if ((state_q != NEXT_ITR) && (|sw_next_itr) && (next_itr_ack_q == '0))
         err_d = 1'b1;
      if ((state_q == NEXT_ITR) && (|sw_swap) && (swap_ack_q == '0))
         err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               s_d       = '0;
               angle_d   = '0;
               itr_d     = '0;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               load_addr = 1'b1;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            phase_d = 1'b1;
            if (phase_q) begin
               capture = 1'b1;
               phase_d = 1'b0;
               state_d = WAIT_SWAP;
            end
         end
         WAIT_SWAP: begin
            if (swap_ok) begin
               swap_ack_d    = ALL_UNITS;
               param_valid_d = (s_q < S_W'(NO_OF_ANGLES));
               if (s_q != '0) begin
                  pe_en_d  = fill_unit ? 2'b01 : 2'b10;
                  pe_sel_d = ~fill_unit;
               end
               s_d     = s_inc;
               angle_d = angle_q + ANGLE_W'(1);
               if (s_inc < S_W'(NO_OF_ANGLES)) begin
                  load_addr = 1'b1;
                  state_d   = FETCH;
               end else if (s_inc == S_W'(NO_OF_ANGLES)) begin
                  state_d = WAIT_SWAP;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (swap_ok) begin
               swap_ack_d = ALL_UNITS;
               pe_en_d    = '0;
               state_d    = NEXT_ITR;
            end
         end
         NEXT_ITR: begin
            if (itr_ok) begin
               next_itr_ack_d = ALL_UNITS;
               if (itr_q == ITR_W'(NO_OF_ITERATIONS - 1)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  itr_d     = itr_q + ITR_W'(1);
                  s_d       = '0;
                  angle_d   = '0;
                  load_addr = 1'b1;
                  state_d   = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         phase_q        <= 1'b0;
         s_q            <= '0;
         angle_q        <= '0;
         itr_q          <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         swap_ack_q     <= '0;
         next_itr_ack_q <= '0;
         pe_en_q        <= '0;
         pe_sel_q       <= 1'b0;
         param_valid_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         s_q            <= s_d;
         angle_q        <= angle_d;
         itr_q          <= itr_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
         swap_ack_q     <= swap_ack_d;
         next_itr_ack_q <= next_itr_ack_d;
         pe_en_q        <= pe_en_d;
         pe_sel_q       <= pe_sel_d;
         param_valid_q  <= param_valid_d;
      end
   end

   nabp_angle_param_fetch #(
      .ANGLE_W (ANGLE_W)
   ) u_fetch (
      .clk              (clk),
      .reset            (reset),
      .load_addr        (load_addr),
      .addr             (angle_d),
      .capture          (capture),
      .lut_sh_accu_base (lut_sh_accu_base),
      .lut_mp_accu_init (lut_mp_accu_init),
      .lut_mp_accu_base (lut_mp_accu_base),
      .lut_angle        (lut_angle),
      .sh_accu_base     (sw_sh_accu_base),
      .mp_accu_init     (sw_mp_accu_init),
      .mp_accu_base     (sw_mp_accu_base)
   );

   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;
   assign sw_swap_ack     = swap_ack_q;
   assign sw_next_itr_ack = next_itr_ack_q;
   assign sw_pe_en        = pe_en_q;
   assign pe_sel          = pe_sel_q;
   assign sw_param_valid  = param_valid_q;

endmodule

// File: tb/tb_nabp_swap_control.sv
// Self-checking bench: instance a (3 angles, 1 iteration) and instance b
// (1 angle, 2 iterations), each driven by a pair of modelled swappable units.
module tb_nabp_swap_control;
   import nabp_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Instance a signals
   logic a_start = 1'b0, a_busy, a_done, a_err, a_param_valid, a_pe_sel;
   logic [7:0] a_lut_angle;
   t_shift_accu_base a_lut_sh = '0, a_sh;
   t_map_accu_init   a_lut_mi = '0, a_mi;
   t_map_accu_base   a_lut_mb = '0, a_mb;
   logic [1:0] a_swap = 2'b00, a_next_itr = 2'b00, a_swap_ack, a_next_itr_ack, a_pe_en;

   // Instance b signals
   logic b_start = 1'b0, b_busy, b_done, b_err, b_param_valid, b_pe_sel;
   logic [7:0] b_lut_angle;
   t_shift_accu_base b_lut_sh = '0, b_sh;
   t_map_accu_init   b_lut_mi = '0, b_mi;
   t_map_accu_base   b_lut_mb = '0, b_mb;
   logic [1:0] b_swap = 2'b00, b_next_itr = 2'b00, b_swap_ack, b_next_itr_ack, b_pe_en;

   int total = 0;
   int passed = 0;

   typedef struct {
      logic             valid;
      t_shift_accu_base sh;
      t_map_accu_init   mi;
      t_map_accu_base   mb;
      logic [1:0]       pe_en;
      logic             pe_sel;
   } swap_exp_t;
   swap_exp_t exp_q[$];

   nabp_swap_control #(.NO_OF_ANGLES(3), .NO_OF_ITERATIONS(1), .ANGLE_W(8)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
      .lut_angle(a_lut_angle), .lut_sh_accu_base(a_lut_sh), .lut_mp_accu_init(a_lut_mi),
      .lut_mp_accu_base(a_lut_mb), .sw_swap(a_swap), .sw_next_itr(a_next_itr),
      .sw_swap_ack(a_swap_ack), .sw_next_itr_ack(a_next_itr_ack), .sw_pe_en(a_pe_en),
      .sw_param_valid(a_param_valid), .sw_sh_accu_base(a_sh), .sw_mp_accu_init(a_mi),
      .sw_mp_accu_base(a_mb), .pe_sel(a_pe_sel)
   );

   nabp_swap_control #(.NO_OF_ANGLES(1), .NO_OF_ITERATIONS(2), .ANGLE_W(8)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
      .lut_angle(b_lut_angle), .lut_sh_accu_base(b_lut_sh), .lut_mp_accu_init(b_lut_mi),
      .lut_mp_accu_base(b_lut_mb), .sw_swap(b_swap), .sw_next_itr(b_next_itr),
      .sw_swap_ack(b_swap_ack), .sw_next_itr_ack(b_next_itr_ack), .sw_pe_en(b_pe_en),
      .sw_param_valid(b_param_valid), .sw_sh_accu_base(b_sh), .sw_mp_accu_init(b_mi),
      .sw_mp_accu_base(b_mb), .pe_sel(b_pe_sel)
   );

   // Angle LUTs with one cycle of read latency: angle k -> 0x100+k / 0x200+k / 0x300+k.
   always @(posedge clk) begin
      a_lut_sh <= 16'h0100 + 16'(a_lut_angle);
      a_lut_mi <= 16'h0200 + 16'(a_lut_angle);
      a_lut_mb <= 16'h0300 + 16'(a_lut_angle);
      b_lut_sh <= 16'h0100 + 16'(b_lut_angle);
      b_lut_mi <= 16'h0200 + 16'(b_lut_angle);
      b_lut_mb <= 16'h0300 + 16'(b_lut_angle);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_a();
      a_start = 1'b1;
      step(1);
      a_start = 1'b0;
   endtask

   task automatic start_b();
      b_start = 1'b1;
      step(1);
      b_start = 1'b0;
   endtask

   // Unit pair of instance a requests a swap; unit 1 may join u1_delay cycles late.
   task automatic swap_a(input int u1_delay, output bit got, output int lat);
      int both_at;
      got = 1'b0;
      lat = 0;
      a_swap[0] = 1'b1;
      a_swap[1] = (u1_delay == 0);
      both_at = (u1_delay == 0) ? 0 : -1;
      for (int c = 1; c <= 200 && !got; c++) begin
         step(1);
         if (a_swap_ack != 2'b00) begin
            got = 1'b1;
            lat = (both_at < 0) ? 0 : c - both_at;
            a_swap = 2'b00;
         end else if (c == u1_delay) begin
            a_swap[1] = 1'b1;
            both_at = c;
         end
      end
      a_swap = 2'b00;
   endtask

   task automatic itr_a(output bit got);
      got = 1'b0;
      a_next_itr = 2'b11;
      for (int c = 1; c <= 200 && !got; c++) begin
         step(1);
         if (a_next_itr_ack != 2'b00) got = 1'b1;
      end
      a_next_itr = 2'b00;
   endtask

   task automatic swap_b(output bit got);
      got = 1'b0;
      b_swap = 2'b11;
      for (int c = 1; c <= 200 && !got; c++) begin
         step(1);
         if (b_swap_ack != 2'b00) got = 1'b1;
      end
      b_swap = 2'b00;
   endtask

   task automatic itr_b(output bit got);
      got = 1'b0;
      b_next_itr = 2'b11;
      for (int c = 1; c <= 200 && !got; c++) begin
         step(1);
         if (b_next_itr_ack != 2'b00) got = 1'b1;
      end
      b_next_itr = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      total++; if (a_busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", a_busy); else passed++;
      total++; if (a_done !== 1'b0 || a_err !== 1'b0) $display("[TB] FAIL reset_done_err got=%b%b exp=00", a_done, a_err); else passed++;
      total++; if (a_swap_ack !== 2'b00 || a_next_itr_ack !== 2'b00) $display("[TB] FAIL reset_acks got=%b/%b exp=00/00", a_swap_ack, a_next_itr_ack); else passed++;
      total++; if (a_pe_en !== 2'b00 || a_pe_sel !== 1'b0 || a_param_valid !== 1'b0) $display("[TB] FAIL reset_pe got=%b/%b/%b exp=00/0/0", a_pe_en, a_pe_sel, a_param_valid); else passed++;
      total++; if (a_sh !== 16'h0 || a_mi !== 16'h0 || a_mb !== 16'h0 || a_lut_angle !== 8'h0) $display("[TB] FAIL reset_bus got=%h/%h/%h/%h exp=0", a_sh, a_mi, a_mb, a_lut_angle); else passed++;
   endtask

   task automatic test_full_run();
      swap_exp_t e, o;
      bit got;
      int lat, swaps;
      t_shift_accu_base cur_sh;
      t_map_accu_init   cur_mi;
      t_map_accu_base   cur_mb;
      logic cur_sel;
      cur_sh = '0; cur_mi = '0; cur_mb = '0; cur_sel = 1'b0; swaps = 0;
      start_a();
      for (int s = 0; s <= 4; s++) begin
         e.valid = (s < 3);
         if (s < 3) begin
            cur_sh = 16'h0100 + 16'(s);
            cur_mi = 16'h0200 + 16'(s);
            cur_mb = 16'h0300 + 16'(s);
         end
         e.sh = cur_sh; e.mi = cur_mi; e.mb = cur_mb;
         // Filling unit f = s%2; the other unit owns the PEs from swap 1 until the drain swap.
         if (s == 0 || s == 4) e.pe_en = 2'b00;
         else e.pe_en = (s % 2 == 1) ? 2'b01 : 2'b10;
         if (s >= 1 && s <= 3) cur_sel = (s % 2 == 1) ? 1'b0 : 1'b1;
         e.pe_sel = cur_sel;
         exp_q.push_back(e);
         swap_a(0, got, lat);
         if (got) swaps++;
         o = exp_q.pop_front();
         total++; if (a_swap_ack !== 2'b11) $display("[TB] FAIL run_ack s=%0d got=%b exp=11", s, a_swap_ack); else passed++;
         total++; if (a_param_valid !== o.valid) $display("[TB] FAIL run_valid s=%0d got=%b exp=%b", s, a_param_valid, o.valid); else passed++;
         total++; if (a_sh !== o.sh || a_mi !== o.mi || a_mb !== o.mb) $display("[TB] FAIL run_bus s=%0d got=%h/%h/%h exp=%h/%h/%h", s, a_sh, a_mi, a_mb, o.sh, o.mi, o.mb); else passed++;
         total++; if (a_pe_en !== o.pe_en || a_pe_sel !== o.pe_sel) $display("[TB] FAIL run_pe s=%0d got=%b/%b exp=%b/%b", s, a_pe_en, a_pe_sel, o.pe_en, o.pe_sel); else passed++;
         step(2);
      end
      total++; if (swaps !== 5) $display("[TB] FAIL run_swap_count got=%0d exp=5", swaps); else passed++;
      itr_a(got);
      total++; if (a_next_itr_ack !== 2'b11) $display("[TB] FAIL run_itr_ack got=%b exp=11", a_next_itr_ack); else passed++;
      total++; if (a_done !== 1'b1 || a_busy !== 1'b0) $display("[TB] FAIL run_done got done=%b busy=%b exp 1/0", a_done, a_busy); else passed++;
      step(1);
      total++; if (a_done !== 1'b0 || a_err !== 1'b0 || a_pe_en !== 2'b00) $display("[TB] FAIL run_after got done=%b err=%b pe=%b exp 0/0/00", a_done, a_err, a_pe_en); else passed++;
   endtask

   task automatic test_stall_and_reset();
      bit got;
      int lat;
      start_a();
      swap_a(20, got, lat);
      total++; if (lat !== 1) $display("[TB] FAIL stall_latency got=%0d exp=1", lat); else passed++;
      total++; if (a_swap_ack !== 2'b11 || a_param_valid !== 1'b1) $display("[TB] FAIL stall_ack got=%b/%b exp=11/1", a_swap_ack, a_param_valid); else passed++;
      step(2);
      swap_a(0, got, lat);
      total++; if (a_pe_en !== 2'b01) $display("[TB] FAIL pre_reset_pe got=%b exp=01", a_pe_en); else passed++;
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      total++; if (a_pe_en !== 2'b00 || a_swap_ack !== 2'b00 || a_next_itr_ack !== 2'b00) $display("[TB] FAIL midreset_pe_ack got=%b/%b/%b exp=0", a_pe_en, a_swap_ack, a_next_itr_ack); else passed++;
      total++; if (a_busy !== 1'b0 || a_param_valid !== 1'b0 || a_pe_sel !== 1'b0 || a_sh !== 16'h0 || a_lut_angle !== 8'h0) $display("[TB] FAIL midreset_regs got busy=%b pv=%b sel=%b sh=%h ang=%h exp 0", a_busy, a_param_valid, a_pe_sel, a_sh, a_lut_angle); else passed++;
      start_a();
      swap_a(0, got, lat);
      total++; if (a_param_valid !== 1'b1 || a_sh !== 16'h0100 || a_pe_en !== 2'b00) $display("[TB] FAIL replay_angle0 got pv=%b sh=%h pe=%b exp 1/0100/00", a_param_valid, a_sh, a_pe_en); else passed++;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_err();
      bit got;
      int lat;
      start_a();
      step(2);
      a_next_itr = 2'b01;
      step(1);
      a_next_itr = 2'b00;
      total++; if (a_err !== 1'b1 || a_busy !== 1'b1 || a_swap_ack !== 2'b00) $display("[TB] FAIL err_set got err=%b busy=%b ack=%b exp 1/1/00", a_err, a_busy, a_swap_ack); else passed++;
      a_start = 1'b1;
      step(1);
      a_start = 1'b0;
      total++; if (a_err !== 1'b1 || a_busy !== 1'b1) $display("[TB] FAIL start_while_busy got err=%b busy=%b exp 1/1", a_err, a_busy); else passed++;
      swap_a(0, got, lat);
      total++; if (a_param_valid !== 1'b1 || a_sh !== 16'h0100 || a_swap_ack !== 2'b11) $display("[TB] FAIL err_fsm_unaffected got pv=%b sh=%h ack=%b exp 1/0100/11", a_param_valid, a_sh, a_swap_ack); else passed++;
      for (int s = 1; s <= 4; s++) begin
         step(2);
         swap_a(0, got, lat);
         total++; if (!got) $display("[TB] FAIL err_run_swap s=%0d got=timeout exp=ack", s); else passed++;
      end
      step(2);
      itr_a(got);
      total++; if (a_done !== 1'b1 || a_err !== 1'b1) $display("[TB] FAIL err_sticky_done got done=%b err=%b exp 1/1", a_done, a_err); else passed++;
      step(1);
      start_a();
      total++; if (a_err !== 1'b0 || a_busy !== 1'b1) $display("[TB] FAIL err_clear_on_start got err=%b busy=%b exp 0/1", a_err, a_busy); else passed++;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_single_angle();
      bit got;
      start_b();
      for (int itr = 0; itr < 2; itr++) begin
         for (int k = 0; k < 3; k++) begin
            swap_b(got);
            total++; if (!got || b_param_valid !== (k == 0)) $display("[TB] FAIL b_swap itr=%0d k=%0d got ack=%b pv=%b exp pv=%b", itr, k, got, b_param_valid, (k == 0)); else passed++;
            if (k == 0) begin
               total++; if (b_lut_angle !== 8'h00 || b_sh !== 16'h0100) $display("[TB] FAIL b_angle itr=%0d got ang=%h sh=%h exp 00/0100", itr, b_lut_angle, b_sh); else passed++;
            end
            step(2);
         end
         itr_b(got);
         total++; if (!got || b_done !== (itr == 1) || b_busy !== (itr == 0)) $display("[TB] FAIL b_next_itr itr=%0d got ack=%b done=%b busy=%b", itr, got, b_done, b_busy); else passed++;
         step(2);
      end
      total++; if (b_done !== 1'b0 || b_busy !== 1'b0) $display("[TB] FAIL b_idle got done=%b busy=%b exp 0/0", b_done, b_busy); else passed++;
   endtask

   initial begin
      step(1);
      test_reset();
      test_full_run();
      test_stall_and_reset();
      test_err();
      test_single_angle();
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
